// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit-side controllers.
// Holds the arbiter state encoding, requester count and transfer timeout default.
package uart_ctrl_pkg;

    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 8000;
    localparam int ID_W               = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_CLR  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    // Round-robin successor of a requester index; wraps 3 -> 0.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return id + {{(ID_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first valid requester at or after ptr,
// wrapping past the highest index back to 0.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    logic [ID_W-1:0] idx_s;
    logic            found_s;

    // Scan from ptr upward; the first valid index seen wins.
    always_comb begin
        winner  = {ID_W{1'b0}};
        found_s = 1'b0;
        idx_s   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s   = ptr + ID_W'(i);
            winner  = (!found_s && valid[idx_s]) ? idx_s : winner;
            found_s = found_s | valid[idx_s];
        end
        any = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to one UART transmitter,
// with a per-transfer completion timeout.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic               busy_q, busy_d;
    logic               to_q, to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    winner_s;
    logic               any_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = {NUM_REQ{1'b0}};
        start_d = 1'b0;
        data_d  = data_q;
        gid_d   = gid_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (enable && any_s) begin
                    state_d           = START;
                    data_d            = req_data[8*winner_s +: 8];
                    gid_d             = winner_s;
                    ready_d[winner_s] = 1'b1;
                    start_d           = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = WAIT_CLR;
                cnt_d   = {CNT_W{1'b0}};
            end
            WAIT_CLR, WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes priority over a timeout landing on the same cycle.
                if (state_q == WAIT_DONE && tx_done) begin
                    state_d = IDLE;
                    ptr_d   = next_id(gid_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    ptr_d   = next_id(gid_q);
                    to_d    = 1'b1;
                end else if (state_q == WAIT_CLR && !tx_done) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= {ID_W{1'b0}};
            ready_q <= {NUM_REQ{1'b0}};
            start_q <= 1'b0;
            data_q  <= 8'h00;
            gid_q   <= {ID_W{1'b0}};
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            start_q <= start_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;

endmodule
